// File: rtl/divider_pkg.sv
// Shared types and constants for the divider sequencer.
package divider_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_ITER  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // Quotient reported when a zero divisor is short-circuited.
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/divider_ctrl_if.sv
// Request/result handshake plus the divider_32 hookup for divider_ctrl.
interface divider_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_start;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic             out_busy;
  logic             out_done;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic             out_div_zero;
  logic             out_div_reset;
  logic [WIDTH-1:0] out_div_dividend;
  logic [WIDTH-1:0] out_div_divisor;
  logic [WIDTH-1:0] in_div_quotient;
  logic [WIDTH-1:0] in_div_remainder;

  // Requester and divider_32 side.
  modport master (
    output in_start, in_dividend, in_divisor, in_div_quotient, in_div_remainder,
    input  out_busy, out_done, out_quotient, out_remainder, out_div_zero,
           out_div_reset, out_div_dividend, out_div_divisor
  );

  // Sequencer side.
  modport slave (
    input  in_start, in_dividend, in_divisor, in_div_quotient, in_div_remainder,
    output out_busy, out_done, out_quotient, out_remainder, out_div_zero,
           out_div_reset, out_div_dividend, out_div_divisor
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negator: invert the operand and feed the flag in as carry.
module div_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_negate,
  output logic [WIDTH-1:0] out_value_c
);

  logic [WIDTH-1:0] operand_c;

  assign operand_c   = in_value ^ {WIDTH{in_negate}};
  assign out_value_c = operand_c + WIDTH'(in_negate);

endmodule

// File: rtl/divider_ctrl.sv
// Sequencer for the iterative restoring divider: latch operands, run WIDTH iterations, sign-correct.
// Define DIVIDER_CTRL_ZERO_DETECT_EN to short-circuit zero divisors without starting the divider.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           in_reset,
  divider_ctrl_if.slave bus
);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH-1:0] fix_quot_c, fix_rem_c;
  logic             neg_q_q, neg_r_q, zero_q;
  logic             busy_q, busy_d, done_q, done_d;
  logic             div_zero_q, div_zero_d, div_reset_q, div_reset_d;
  logic             accept_c, start_zero_c;

  assign accept_c = (state == ST_IDLE) && bus.in_start;

`ifdef DIVIDER_CTRL_ZERO_DETECT_EN
  assign start_zero_c = (bus.in_divisor == '0);
`else
  assign start_zero_c = 1'b0;
`endif

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
    .in_value    (bus.in_div_quotient),
    .in_negate   (neg_q_q),
    .out_value_c (fix_quot_c)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
    .in_value    (bus.in_div_remainder),
    .in_negate   (neg_r_q),
    .out_value_c (fix_rem_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      div_reset_q <= 1'b1;
      quot_q      <= '0;
      rem_q       <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      div_reset_q <= div_reset_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      if (accept_c) begin
        dividend_q <= bus.in_dividend;
        divisor_q  <= bus.in_divisor;
        neg_q_q    <= bus.in_dividend[WIDTH-1] ^ bus.in_divisor[WIDTH-1];
        neg_r_q    <= bus.in_dividend[WIDTH-1];
        zero_q     <= start_zero_c;
      end
    end
  end

  // Next-state logic; RUN exits after the edge where the counter reads WIDTH-1.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: if (bus.in_start) state_d = start_zero_c ? ST_FIX : ST_LOAD;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and counter.
  always_comb begin
    cnt_d       = cnt;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    div_reset_d = (state_d == ST_LOAD);
    quot_d      = quot_q;
    rem_d       = rem_q;
    unique case (state)
      ST_LOAD: begin
        cnt_d  = '0;
        busy_d = 1'b1;
      end
      ST_RUN:  cnt_d = cnt + CNT_W'(1);
      ST_FIX: begin
        quot_d     = zero_q ? WIDTH'(DIV_ZERO_QUOTIENT) : fix_quot_c;
        rem_d      = zero_q ? dividend_q : fix_rem_c;
        div_zero_d = zero_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.out_busy         = busy_q;
  assign bus.out_done         = done_q;
  assign bus.out_quotient     = quot_q;
  assign bus.out_remainder    = rem_q;
  assign bus.out_div_zero     = div_zero_q;
  assign bus.out_div_reset    = div_reset_q;
  assign bus.out_div_dividend = dividend_q;
  assign bus.out_div_divisor  = divisor_q;

endmodule
